// File: rtl/rs_gf_pkg.sv
// rtl/rs_gf_pkg.sv - GF(2^10) types, constants and arithmetic helpers shared by the RS decoder
package rs_gf_pkg;
  localparam int W     = 10;
  localparam int T     = 11;
  localparam int U_LEN = T + 1;
  localparam int POS_W = 10;
  localparam int CNT_W = 5;

  // x^10 + x^3 + 1
  localparam logic [W:0] PRIM_POLY = 11'h409;

  typedef logic [W-1:0] gf_t;
  typedef gf_t gf_vec_t [U_LEN];

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } cw_state_t;

  function automatic gf_t gf_mul(gf_t a, gf_t b);
    gf_t p;
    p = '0;
    for (int i = W - 1; i >= 0; i--) begin
      p = {p[W-2:0], 1'b0} ^ (p[W-1] ? PRIM_POLY[W-1:0] : '0);
      if (b[i]) p = p ^ a;
    end
    return p;
  endfunction

  // a^(2^W - 2); the exponent has bits 1..W-1 set, and 0 maps to 0
  function automatic gf_t gf_pow_inv(gf_t a);
    gf_t r;
    gf_t s;
    r = gf_t'(1);
    s = a;
    for (int i = 0; i < W; i++) begin
      if (i != 0) r = gf_mul(r, s);
      s = gf_mul(s, s);
    end
    return r;
  endfunction
endpackage

// File: rtl/gf_inv.sv
// rtl/gf_inv.sv - Combinational 1024-entry GF(2^10) inverse ROM, inv(0) = 0
module gf_inv
  import rs_gf_pkg::*;
(
  input  gf_t a,
  output gf_t inv
);
  gf_t rom [2**W];

  for (genvar i = 0; i < 2**W; i++) begin : g_rom
    localparam gf_t INV_I = gf_pow_inv(gf_t'(i));
    assign rom[i] = INV_I;
  end

  assign inv = rom[a];
endmodule

// File: rtl/forney_eval.sv
// rtl/forney_eval.sv - Three-stage Forney error-magnitude pipeline with per-codeword count/fail/done
module forney_eval
  import rs_gf_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cw_start_i,
  input  gf_t              omega_i [T],
  input  gf_vec_t          lambda_i,
  input  logic             in_vld_i,
  input  logic [POS_W-1:0] in_pos_i,
  input  gf_vec_t          in_u_i,
  output logic             in_rdy_o,
  input  logic             up_done_i,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic [POS_W-1:0] out_pos_o,
  output gf_t              out_mag_o,
  output logic [CNT_W-1:0] err_cnt_o,
  output logic             fail_o,
  output logic             done_o
);
  gf_t     omega_q [T];
  gf_vec_t lambda_q;

  logic             s1_vld, s2_vld, s3_vld;
  gf_t              s1_num, s1_den, s2_num, s2_inv, s3_mag;
  logic [POS_W-1:0] s1_pos, s2_pos, s3_pos;
  logic             s2_dz, s3_dz;

  logic             en, accept, hs;
  gf_t              num_c, den_c, inv_c;
  logic [CNT_W-1:0] cnt_inc;
  cw_state_t        state, state_nxt;

  assign en       = ~s3_vld | out_rdy_i;
  assign in_rdy_o = en;
  assign accept   = in_vld_i & en & ~cw_start_i;
  assign hs       = s3_vld & out_rdy_i;

  always_comb begin
    num_c = '0;
    den_c = '0;
    for (int k = 0; k < T; k++) num_c = num_c ^ gf_mul(omega_q[k], in_u_i[k]);
    for (int k = 1; k < U_LEN; k += 2) den_c = den_c ^ gf_mul(lambda_q[k], in_u_i[k]);
  end

  gf_inv u_gf_inv (
    .a   (s1_den),
    .inv (inv_c)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      omega_q  <= '{default: '0};
      lambda_q <= '{default: '0};
    end else if (cw_start_i) begin
      omega_q  <= omega_i;
      lambda_q <= lambda_i;
    end
  end

  // Stages move in lockstep; a restart drops whatever is in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_vld <= 1'b0; s1_num <= '0; s1_den <= '0; s1_pos <= '0;
      s2_vld <= 1'b0; s2_num <= '0; s2_inv <= '0; s2_pos <= '0; s2_dz <= 1'b0;
      s3_vld <= 1'b0; s3_mag <= '0; s3_pos <= '0; s3_dz <= 1'b0;
    end else if (cw_start_i) begin
      s1_vld <= 1'b0;
      s2_vld <= 1'b0;
      s3_vld <= 1'b0;
    end else if (en) begin
      s1_vld <= accept;
      s1_num <= num_c;
      s1_den <= den_c;
      s1_pos <= in_pos_i;
      s2_vld <= s1_vld;
      s2_num <= s1_num;
      s2_inv <= inv_c;
      s2_pos <= s1_pos;
      s2_dz  <= (s1_den == '0);
      s3_vld <= s2_vld;
      s3_mag <= s2_dz ? '0 : gf_mul(s2_num, s2_inv);
      s3_pos <= s2_pos;
      s3_dz  <= s2_dz;
    end
  end

  assign out_vld_o = s3_vld;
  assign out_pos_o = s3_pos;
  assign out_mag_o = s3_mag;

  assign cnt_inc = (err_cnt_o == '1) ? err_cnt_o : err_cnt_o + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_o <= '0;
      fail_o    <= 1'b0;
    end else if (cw_start_i) begin
      err_cnt_o <= '0;
      fail_o    <= 1'b0;
    end else if (hs) begin
      if (s3_dz) begin
        fail_o <= 1'b1;
      end else begin
        err_cnt_o <= cnt_inc;
        if (cnt_inc > CNT_W'(T)) fail_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done_o    = (state == ST_DONE);
    if (cw_start_i) begin
      state_nxt = ST_RUN;
    end else if (state == ST_RUN && up_done_i && !accept && !s1_vld && !s2_vld
                 && (!s3_vld || hs)) begin
      state_nxt = ST_DONE;
    end
  end
endmodule

// File: tb/tb_forney_eval.sv
// tb/tb_forney_eval.sv - Directed self-checking bench for forney_eval
module tb_forney_eval;
  import rs_gf_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, cw_start, in_vld, in_rdy, up_done, out_vld, out_rdy, fail, done;
  gf_t              omega [T];
  gf_vec_t          lambda, in_u;
  logic [POS_W-1:0] in_pos, out_pos;
  gf_t              out_mag;
  logic [CNT_W-1:0] err_cnt;

  forney_eval dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cw_start_i (cw_start),
    .omega_i    (omega),
    .lambda_i   (lambda),
    .in_vld_i   (in_vld),
    .in_pos_i   (in_pos),
    .in_u_i     (in_u),
    .in_rdy_o   (in_rdy),
    .up_done_i  (up_done),
    .out_vld_o  (out_vld),
    .out_rdy_i  (out_rdy),
    .out_pos_o  (out_pos),
    .out_mag_o  (out_mag),
    .err_cnt_o  (err_cnt),
    .fail_o     (fail),
    .done_o     (done)
  );

  typedef struct packed {
    logic [POS_W-1:0] pos;
    gf_t              mag;
  } exp_t;

  int      n_checks = 0;
  int      n_fail   = 0;
  gf_t     cur_om [T];
  gf_vec_t cur_lam;
  gf_t     good_om [T];
  gf_vec_t good_lam;
  exp_t    exp_q [$];
  int      hs_cnt, step_idx, first_hs, last_hs, bp_idx;
  logic    last_acc, prev_stall, bp_en;
  logic [31:0]      bp_pat;
  logic [POS_W-1:0] snap_pos;
  gf_t              snap_mag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // LSB-first shift-and-add multiply, reducing by x^10 = x^3 + 1
  function automatic gf_t mul_ref(gf_t a, gf_t b);
    gf_t p;
    gf_t s;
    p = '0;
    s = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ s;
      s = s[W-1] ? ((s << 1) ^ 10'h009) : (s << 1);
    end
    return p;
  endfunction

  function automatic gf_t inv_ref(gf_t a);
    for (int b = 1; b < 1024; b++)
      if (mul_ref(a, gf_t'(b)) == 10'd1) return gf_t'(b);
    return '0;
  endfunction

  function automatic gf_vec_t make_u(gf_t x);
    gf_vec_t u;
    u[0] = 10'd1;
    for (int k = 1; k < U_LEN; k++) u[k] = mul_ref(u[k-1], x);
    return u;
  endfunction

  function automatic gf_t den_ref(gf_vec_t u);
    gf_t d;
    d = '0;
    for (int k = 1; k < U_LEN; k += 2) d = d ^ mul_ref(cur_lam[k], u[k]);
    return d;
  endfunction

  function automatic gf_t exp_mag(gf_vec_t u);
    gf_t n;
    gf_t d;
    n = '0;
    d = den_ref(u);
    for (int k = 0; k < T; k++) n = n ^ mul_ref(cur_om[k], u[k]);
    return (d == '0) ? '0 : mul_ref(n, inv_ref(d));
  endfunction

  // One clock: inspect the pre-edge handshake, then advance to the next negedge.
  task automatic step();
    logic stall;
    exp_t e;
    #1;
    last_acc = in_vld & in_rdy & ~cw_start;
    stall    = out_vld & ~out_rdy;
    if (stall) check("in_rdy_stall", 32'(in_rdy), 0);
    if (cw_start) begin
      exp_q.delete();
    end else begin
      if (out_vld & out_rdy) begin
        hs_cnt++;
        if (hs_cnt == 1) first_hs = step_idx;
        last_hs = step_idx;
        if (exp_q.size() == 0) begin
          check("unexpected_out", 32'(out_vld), 0);
        end else begin
          e = exp_q.pop_front();
          check("out_pos", 32'(out_pos), 32'(e.pos));
          check("out_mag", 32'(out_mag), 32'(e.mag));
        end
      end
      if (last_acc) exp_q.push_back('{pos: in_pos, mag: exp_mag(in_u)});
    end
    snap_pos   = out_pos;
    snap_mag   = out_mag;
    prev_stall = stall & ~cw_start;
    @(negedge clk);
    step_idx++;
    if (prev_stall) begin
      check("stall_vld", 32'(out_vld), 1);
      check("stall_pos", 32'(out_pos), 32'(snap_pos));
      check("stall_mag", 32'(out_mag), 32'(snap_mag));
    end
    if (bp_en) begin
      out_rdy = bp_pat[bp_idx % 32];
      bp_idx++;
    end
  endtask

  task automatic start_cw();
    cw_start = 1'b1;
    cur_om   = omega;
    cur_lam  = lambda;
    step();
    cw_start = 1'b0;
    hs_cnt   = 0;
  endtask

  task automatic send(input logic [POS_W-1:0] pos, input gf_t x);
    int guard;
    guard  = 0;
    in_vld = 1'b1;
    in_pos = pos;
    in_u   = make_u(x);
    do begin
      step();
      guard++;
    end while (!last_acc && guard < 50);
    check("accepted", 32'(last_acc), 1);
  endtask

  task automatic send_n(input int n, input logic [POS_W-1:0] base);
    gf_t x;
    x = 10'd1;
    for (int i = 0; i < n; i++) begin
      for (int g = 0; g < 1023; g++) begin
        x = mul_ref(x, 10'd2);
        if (den_ref(make_u(x)) != '0) break;
      end
      send(base + POS_W'(i), x);
    end
    in_vld = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard  = 0;
    in_vld = 1'b0;
    while (exp_q.size() != 0 && guard < 100) begin
      step();
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    rst = 1'b1; cw_start = 1'b0; in_vld = 1'b0; in_pos = '0; up_done = 1'b0;
    out_rdy = 1'b1; bp_en = 1'b0; bp_pat = 32'hB3A5_6C19; bp_idx = 0;
    omega = '{default: '0}; lambda = '{default: '0}; in_u = '{default: '0};
    hs_cnt = 0; step_idx = 0; first_hs = 0; last_hs = 0; prev_stall = 1'b0; last_acc = 1'b0;
    for (int k = 0; k < T; k++) good_om[k] = gf_t'(k * 37 + 5);
    for (int k = 0; k < U_LEN; k++) good_lam[k] = gf_t'(k * 91 + 3);

    repeat (2) @(negedge clk);
    check("rst_out_vld", 32'(out_vld), 0);
    check("rst_in_rdy",  32'(in_rdy), 1);
    check("rst_pos",     32'(out_pos), 0);
    check("rst_mag",     32'(out_mag), 0);
    check("rst_err_cnt", 32'(err_cnt), 0);
    check("rst_fail",    32'(fail), 0);
    check("rst_done",    32'(done), 0);
    rst = 1'b0;
    step();

    // Single error: lambda = 1 + a*x, omega = 0x155, u^1 = a^-1 = 0x204
    omega[0] = 10'h155; lambda[1] = 10'h002;
    start_cw();
    in_vld = 1'b1; in_pos = 10'd5; in_u = make_u(10'h204);
    step();
    in_vld = 1'b0;
    step();
    check("lat_s2_vld", 32'(out_vld), 0);
    step();
    check("lat_s3_vld", 32'(out_vld), 1);
    check("single_pos", 32'(out_pos), 5);
    check("single_mag", 32'(out_mag), 'h155);
    check("single_done_pre", 32'(done), 0);
    up_done = 1'b1;
    step();
    check("single_cnt",  32'(err_cnt), 1);
    check("single_fail", 32'(fail), 0);
    check("single_done", 32'(done), 1);
    up_done = 1'b0;

    // Back-to-back burst of T; input coefficients scrambled after the start
    omega = good_om; lambda = good_lam;
    start_cw();
    omega = '{default: 10'h3FF}; lambda = '{default: 10'h3FF};
    send_n(T, 10'd20);
    up_done = 1'b1;
    for (int g = 0; g < 20 && hs_cnt < T; g++) step();
    check("burst_hs",     32'(hs_cnt), 11);
    check("burst_consec", 32'(last_hs - first_hs), 10);
    check("burst_cnt",    32'(err_cnt), 11);
    check("burst_fail",   32'(fail), 0);
    check("burst_done",   32'(done), 1);
    up_done = 1'b0;

    // Backpressure
    omega = good_om; lambda = good_lam;
    start_cw();
    bp_en = 1'b1;
    send_n(8, 10'd40);
    drain();
    bp_en = 1'b0; out_rdy = 1'b1;
    check("bp_hs",  32'(hs_cnt), 8);
    check("bp_cnt", 32'(err_cnt), 8);

    // Zero denominator: no odd lambda terms
    lambda = '{default: '0}; lambda[0] = 10'h001; lambda[2] = 10'h0AB;
    start_cw();
    send(10'd100, 10'h002);
    send(10'd101, 10'h004);
    drain();
    check("dz_cnt",  32'(err_cnt), 0);
    check("dz_fail", 32'(fail), 1);
    repeat (3) step();
    check("dz_fail_sticky", 32'(fail), 1);

    // Overcount: T+1 magnitudes
    lambda = good_lam;
    start_cw();
    check("oc_fail_clr", 32'(fail), 0);
    send_n(T + 1, 10'd60);
    drain();
    check("oc_cnt",  32'(err_cnt), 12);
    check("oc_fail", 32'(fail), 1);
    up_done = 1'b1;
    step();
    check("oc_done", 32'(done), 1);
    up_done = 1'b0;

    // Restart with three entries in flight and a valid presented during the start
    out_rdy = 1'b0;
    send(10'd80, 10'h002);
    send(10'd81, 10'h004);
    send(10'd82, 10'h008);
    omega = '{default: '0}; omega[0] = 10'h0F0;
    lambda = '{default: '0}; lambda[1] = 10'h002;
    start_cw();
    check("mf_vld",  32'(out_vld), 0);
    check("mf_cnt",  32'(err_cnt), 0);
    check("mf_fail", 32'(fail), 0);
    check("mf_done", 32'(done), 0);
    in_vld = 1'b0; out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("mf_no_out", 32'(out_vld), 0);
    end
    send(10'd7, 10'h204);
    in_vld = 1'b0;
    step();
    step();
    check("mf_new_vld", 32'(out_vld), 1);
    check("mf_new_mag", 32'(out_mag), 'h0F0);
    drain();
    check("mf_new_cnt", 32'(err_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
